// File: rtl/digit_serial_adder_pkg.sv
// adder_pkg -- shared definitions for the digit-serial adder slice.
//   state_t        : FSM state encoding (IDLE, RUN, DONE)
//   num_digits()   : number of DIGIT-wide slices in a WIDTH-bit operand
//   idx_width()    : width of a counter that indexes those slices
//   params_legal() : WIDTH/DIGIT legality rule used by the top level
// Optional feature macro: DIGIT_SERIAL_ADDER_OVF_EN (not used in this file).
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of digit slices per operand.
  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction

  // Slice index width; a single slice still needs a 1-bit index.
  function automatic int idx_width(input int n);
    int w;
    if (n > 32'sd1) begin
      w = $clog2(n);
    end else begin
      w = 32'sd1;
    end
    return w;
  endfunction

  // WIDTH in 4..64, DIGIT in 1..WIDTH and an exact divisor of WIDTH.
  function automatic bit params_legal(input int width, input int digit);
    bit ok;
    ok = (width >= 32'sd4) && (width <= 32'sd64) &&
         (digit >= 32'sd1) && (digit <= width) &&
         ((width % digit) == 32'sd0);
    return ok;
  endfunction

endpackage

// File: rtl/digit_serial_adder_if.sv
// digit_serial_adder_if -- operand/result handshake bundle.
//   in_valid/in_ready   : operand handshake (a, b, cin)
//   out_valid/out_ready : result handshake (sum, plus ovf when enabled)
//   master modport      : producer/consumer side
//   slave modport       : adder side
// Optional feature macro: DIGIT_SERIAL_ADDER_OVF_EN adds the ovf signal.
interface digit_serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, cin, out_ready,
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, sum
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, sum
  );
endinterface

// File: rtl/digit_serial_adder_digit_add.sv
// digit_add -- combinational DIGIT-bit ripple-carry adder slice.
//   x, y : operand digits
//   ci   : carry into bit 0
//   s    : DIGIT sum bits
//   co   : carry out of the MSB
//   cmsb : carry into the MSB (only with DIGIT_SERIAL_ADDER_OVF_EN)
module digit_add #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  output logic             cmsb,
`endif
  output logic             co
);

  // c_s[i] is the carry into bit i; c_s[DIGIT] leaves the slice.
  logic [DIGIT:0] c_s;

  assign c_s[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]     = x[i] ^ y[i] ^ c_s[i];
    assign c_s[i+1] = (x[i] & y[i]) | (x[i] & c_s[i]) | (y[i] & c_s[i]);
  end

  assign co = c_s[DIGIT];

`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  assign cmsb = c_s[DIGIT-1];
`endif

endmodule

// File: rtl/digit_serial_adder.sv
// digit_serial_adder -- adds two WIDTH-bit unsigned operands plus carry-in,
// DIGIT bits per clock, behind a valid/ready handshake.
//   clk  : clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : digit_serial_adder_if.slave (in_valid/in_ready/a/b/cin,
//          out_valid/out_ready/sum[WIDTH:0], ovf when enabled)
// Operands are latched on accept, so the source may change them freely
// while the add is in progress. Result appears N = WIDTH/DIGIT cycles later.
// Optional feature macro: DIGIT_SERIAL_ADDER_OVF_EN adds a registered
// two's-complement overflow flag (bus.ovf).
module digit_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 4
) (
  input logic                clk,
  input logic                rst,
  digit_serial_adder_if.slave bus
);

  localparam int N     = num_digits(WIDTH, DIGIT);
  localparam int IDX_W = idx_width(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 32'sd1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(32'sd1);

  if (!params_legal(WIDTH, DIGIT)) begin : g_bad_params
    $error("digit_serial_adder: WIDTH must be 4..64 and a multiple of DIGIT");
  end

  state_t                        state_r;
  logic [N-1:0][DIGIT-1:0]       a_r;
  logic [N-1:0][DIGIT-1:0]       b_r;
  logic [N-1:0][DIGIT-1:0]       res_r;
  logic                          carry_r;
  logic                          cout_r;
  logic [IDX_W-1:0]              cnt_r;
  logic                          in_ready_r;
  logic                          out_valid_r;
  logic [DIGIT-1:0]              dsum_s;
  logic                          dcout_s;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  logic                          dcmsb_s;
  logic                          ovf_r;
`endif

  digit_add #(
    .DIGIT (DIGIT)
  ) u_digit_add (
    .x    (a_r[cnt_r]),
    .y    (b_r[cnt_r]),
    .ci   (carry_r),
    .s    (dsum_s),
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    .cmsb (dcmsb_s),
`endif
    .co   (dcout_s)
  );

  // FSM, operand capture, per-digit result write and carry chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      a_r         <= '0;
      b_r         <= '0;
      res_r       <= '0;
      carry_r     <= 1'b0;
      cout_r      <= 1'b0;
      cnt_r       <= '0;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
      ovf_r       <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            a_r        <= bus.a;
            b_r        <= bus.b;
            carry_r    <= bus.cin;
            cnt_r      <= '0;
            in_ready_r <= 1'b0;
            state_r    <= RUN;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        RUN: begin
          res_r[cnt_r] <= dsum_s;
          carry_r      <= dcout_s;
          if (cnt_r == LAST_IDX) begin
            // The last slice's carry-out is the result MSB; its carry-in
            // versus carry-out at the operand MSB is the signed overflow.
            cout_r      <= dcout_s;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
            ovf_r       <= dcmsb_s ^ dcout_s;
`endif
          end else begin
            cnt_r <= cnt_r + IDX_ONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = {cout_r, res_r};
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  assign bus.ovf       = ovf_r;
`endif

endmodule

// File: doc/digit_serial_adder.md
DIGIT_SERIAL_ADDER -- requirements
Module: digit_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits; legal values 4 to 64.
REQ-002 SHALL have parameter DIGIT, default 4: bits added per cycle; WIDTH SHALL be an integer multiple of DIGIT.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous reset, active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: operands a, b and cin are valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts operands.
REQ-007 SHALL have port a, input, WIDTH bits: first operand (unsigned).
REQ-008 SHALL have port b, input, WIDTH bits: second operand (unsigned).
REQ-009 SHALL have port cin, input, 1 bit: carry-in.
REQ-010 SHALL have port out_valid, output, 1 bit: sum is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts sum.
REQ-012 SHALL have port sum, output, WIDTH+1 bits: a+b+cin; bit WIDTH is the carry-out.

Function
REQ-013 SHALL run a three-state FSM with states IDLE, RUN and DONE; the reset state is IDLE.
REQ-014 SHALL drive in_ready=1 only in IDLE.
REQ-015 SHALL, on in_valid&&in_ready, capture a, b and cin into internal registers, clear the digit counter and go to RUN.
REQ-016 SHALL, in RUN, add digit i (bits i*DIGIT+DIGIT-1 down to i*DIGIT) of both operands plus the registered carry each cycle, and write that digit of the result.
REQ-017 SHALL seed the carry for digit 0 with the captured cin; each digit's carry-out SHALL be registered and feed the next digit.
REQ-018 SHALL, after digit N-1 (N=WIDTH/DIGIT), write the final carry into sum[WIDTH] and go to DONE.
REQ-019 Latency: if the accept edge is edge k, out_valid SHALL be 1 after edge k+N; with WIDTH=8 and DIGIT=4 this is 2 cycles.
REQ-020 SHALL drive out_valid=1 only in DONE, and hold sum stable while out_valid=1.
REQ-021 SHALL go from DONE to IDLE on out_ready=1; out_valid SHALL clear and in_ready SHALL rise on the same edge.
REQ-022 SHALL keep sum unchanged outside DONE until the next RUN overwrites it digit by digit.
REQ-023 SHALL ignore in_valid while in RUN or DONE; changes on a, b and cin after the accept edge SHALL NOT affect the result.
REQ-024 SHALL handle DIGIT==WIDTH: N=1, single RUN cycle.
REQ-025 SHALL discard carry beyond bit WIDTH; the result is exact modulo 2^(WIDTH+1), never truncated.

Reset
REQ-026 SHALL, while rst=1 at a rising edge, go to IDLE and set in_ready=1, out_valid=0, sum=0, carry=0, digit counter=0.
REQ-027 SHALL, on reset during RUN or DONE, abort the operation with no out_valid pulse.
REQ-028 SHALL give rst priority over in_valid and out_ready on the same edge.

Configuration
REQ-029 SHALL, with macro DIGIT_SERIAL_ADDER_OVF_EN defined, add output port ovf, 1 bit: two's-complement signed overflow of a+b+cin, i.e. carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-030 ovf SHALL be valid with out_valid, hold with sum, and reset to 0.
REQ-031 SHALL, without DIGIT_SERIAL_ADDER_OVF_EN, have no ovf port and no overflow logic.

Structure
REQ-032 SHALL take the FSM state enum (IDLE, RUN, DONE) from shared package adder_pkg.
REQ-033 SHALL place a WIDTH/DIGIT constant function and parameter-legality checks in adder_pkg.
REQ-034 SHALL implement the per-cycle digit adder as sub-module digit_add: a combinational DIGIT-bit ripple of full adders with carry-in, DIGIT sum bits and carry-out.
REQ-035 When ovf is enabled, digit_add SHALL also output the carry into its MSB.

Verification (WIDTH=8, DIGIT=4 unless stated)
REQ-036 a=8'hAD, b=8'h29, cin=0 -> after 2 cycles out_valid=1, sum=9'h0D6.
REQ-037 a=8'hFF, b=8'h00, cin=1 -> sum=9'h100, showing carry across both digits.
REQ-038 Hold out_ready=0 for 5 cycles after out_valid -> sum stays 9'h0D6, in_ready=0; pulsing out_ready then gives in_ready=1 next cycle.
REQ-039 Assert rst one cycle after accepting a=8'hFF, b=8'h01 -> out_valid never rises, sum=0, in_ready=1.
REQ-040 With DIGIT_SERIAL_ADDER_OVF_EN, a=8'h7F, b=8'h01 -> sum=9'h080, ovf=1; a=8'h80, b=8'h80 -> sum=9'h100, ovf=1; a=8'h10, b=8'h20 -> ovf=0.
REQ-041 WIDTH=4, DIGIT=4: a=4'b0110, b=4'b1110, cin=0 -> after 1 cycle sum=5'b10100.
